// File: rtl/dti_lp_ctrl.sv
// Low-power sequencer for one DTI router: turns a Q-channel quiescence
// request into stall / drain / optional flush, then accepts or denies.
module dti_lp_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter bit          FLUSH_EN      = 1'b1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             qreqn,
    output logic             qacceptn,
    output logic             qdeny,
    output logic             qactive,
    input  logic             req_tvalid,
    input  logic             req_tready,
    input  logic             req_tlast,
    input  logic             idle,
    output logic             stall,
    output logic             partial_reset,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned        TMR_W    = 16;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT_EOP,
        ST_DRAIN,
        ST_FLUSH,
        ST_STOPPED,
        ST_DENIED
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               mid_pkt_q, mid_pkt_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;
    logic               stall_q, stall_d;
    logic               partial_reset_q, partial_reset_d;
    logic               qacceptn_q, qacceptn_d;
    logic               qdeny_q, qdeny_d;
    logic               qactive_q, qactive_d;
    logic               hs;

    // Next-state, packet tracking, timer and registered-output decode
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        flush_count_d = flush_count_q;
        hs            = req_tvalid & req_tready;
        mid_pkt_d     = mid_pkt_q;
        if (hs) begin
            mid_pkt_d = ~req_tlast;
        end

        unique case (state_q)
            ST_RUN: begin
                if (!qreqn) begin
                    state_d = ST_WAIT_EOP;
                end
            end
            ST_WAIT_EOP: begin
                // only stall once no packet remains open after this cycle
                if (!mid_pkt_d) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end
            end
            ST_DRAIN: begin
                timer_d = timer_q + TMR_W'(1);
                if (idle) begin
                    state_d = ST_STOPPED;
                end else if (timer_q == TMR_LAST) begin
                    state_d = FLUSH_EN ? ST_FLUSH : ST_DENIED;
                end
            end
            ST_FLUSH: begin
                if (idle) begin
                    state_d = ST_STOPPED;
                    if (flush_count_q != '1) begin
                        flush_count_d = flush_count_q + CNT_W'(1);
                    end
                end
            end
            ST_STOPPED: begin
                if (qreqn) begin
                    state_d = ST_RUN;
                end
            end
            ST_DENIED: begin
                if (qreqn) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // outputs are a registered decode of the state being entered
        stall_d         = (state_d == ST_DRAIN) || (state_d == ST_FLUSH) ||
                          (state_d == ST_STOPPED);
        partial_reset_d = (state_d == ST_FLUSH);
        qacceptn_d      = (state_d != ST_STOPPED);
        qdeny_d         = (state_d == ST_DENIED);
        qactive_d       = ~idle | req_tvalid;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            timer_q         <= '0;
            mid_pkt_q       <= 1'b0;
            flush_count_q   <= '0;
            stall_q         <= 1'b0;
            partial_reset_q <= 1'b0;
            qacceptn_q      <= 1'b1;
            qdeny_q         <= 1'b0;
            qactive_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            mid_pkt_q       <= mid_pkt_d;
            flush_count_q   <= flush_count_d;
            stall_q         <= stall_d;
            partial_reset_q <= partial_reset_d;
            qacceptn_q      <= qacceptn_d;
            qdeny_q         <= qdeny_d;
            qactive_q       <= qactive_d;
        end
    end

    assign stall         = stall_q;
    assign partial_reset = partial_reset_q;
    assign qacceptn      = qacceptn_q;
    assign qdeny         = qdeny_q;
    assign qactive       = qactive_q;
    assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_dti_lp_ctrl.sv
// Bench for dti_lp_ctrl: a flush-enabled and a deny-configured instance share
// stimulus; a timestamp-based reference model predicts every output each cycle.
module tb_dti_lp_ctrl;

    localparam int T = 16;
    localparam int P_RUN = 0, P_WAIT = 1, P_DRAIN = 2, P_FLUSH = 3, P_STOP = 4, P_DENY = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, qreqn, req_tvalid, tready_raw, req_tlast, idle;
    logic       qacceptn_f, qdeny_f, qactive_f, stall_f, prst_f, tready_f;
    logic       qacceptn_d, qdeny_d, qactive_d, stall_d, prst_d, tready_d;
    logic [7:0] fcnt_f, fcnt_d;

    // router emulation: ready is gated by stall
    assign tready_f = tready_raw & ~stall_f;
    assign tready_d = tready_raw & ~stall_d;

    dti_lp_ctrl #(.DRAIN_TIMEOUT(T), .FLUSH_EN(1'b1), .CNT_W(8)) dut_f (
        .clk(clk), .rst_n(rst_n), .qreqn(qreqn), .qacceptn(qacceptn_f), .qdeny(qdeny_f),
        .qactive(qactive_f), .req_tvalid(req_tvalid), .req_tready(tready_f),
        .req_tlast(req_tlast), .idle(idle), .stall(stall_f), .partial_reset(prst_f),
        .flush_count(fcnt_f));

    dti_lp_ctrl #(.DRAIN_TIMEOUT(T), .FLUSH_EN(1'b0), .CNT_W(8)) dut_d (
        .clk(clk), .rst_n(rst_n), .qreqn(qreqn), .qacceptn(qacceptn_d), .qdeny(qdeny_d),
        .qactive(qactive_d), .req_tvalid(req_tvalid), .req_tready(tready_d),
        .req_tlast(req_tlast), .idle(idle), .stall(stall_d), .partial_reset(prst_d),
        .flush_count(fcnt_d));

    typedef struct {
        int phase;
        int t0;
        bit mid;
        bit stall, prst, qaccn, qdeny, qact;
        int fcnt;
    } mdl_t;

    mdl_t mf, md;
    int   cyc, checks, errors, beats;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = P_RUN; m.t0 = 0; m.mid = 1'b0;
        m.stall = 1'b0; m.prst = 1'b0; m.qaccn = 1'b1; m.qdeny = 1'b0; m.qact = 1'b0;
        m.fcnt = 0;
        return m;
    endfunction

    // one clock edge of the specified behaviour, with DRAIN timed by timestamp
    function automatic mdl_t step(mdl_t m, bit flush_en, bit q, bit v, bit r, bit l, bit i, int now);
        mdl_t n = m;
        bit hs = v & r & ~m.stall;
        n.mid  = hs ? ~l : m.mid;
        n.qact = ~i | v;
        case (m.phase)
            P_RUN:   if (!q) n.phase = P_WAIT;
            P_WAIT:  if (!n.mid) begin n.phase = P_DRAIN; n.t0 = now; end
            P_DRAIN: begin
                if (i) n.phase = P_STOP;
                else if (now - m.t0 == T) n.phase = flush_en ? P_FLUSH : P_DENY;
            end
            P_FLUSH: if (i) begin n.phase = P_STOP; n.fcnt = (m.fcnt < 255) ? m.fcnt + 1 : 255; end
            P_STOP:  if (q) n.phase = P_RUN;
            default: if (q) n.phase = P_RUN;
        endcase
        n.stall = (n.phase == P_DRAIN) || (n.phase == P_FLUSH) || (n.phase == P_STOP);
        n.prst  = (n.phase == P_FLUSH);
        n.qaccn = (n.phase != P_STOP);
        n.qdeny = (n.phase == P_DENY);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cmp_all();
        chk("f.stall", stall_f, mf.stall);       chk("d.stall", stall_d, md.stall);
        chk("f.prst", prst_f, mf.prst);          chk("d.prst", prst_d, md.prst);
        chk("f.qacceptn", qacceptn_f, mf.qaccn); chk("d.qacceptn", qacceptn_d, md.qaccn);
        chk("f.qdeny", qdeny_f, mf.qdeny);       chk("d.qdeny", qdeny_d, md.qdeny);
        chk("f.qactive", qactive_f, mf.qact);    chk("d.qactive", qactive_d, md.qact);
        chk("f.fcnt", fcnt_f, mf.fcnt);          chk("d.fcnt", fcnt_d, md.fcnt);
    endtask

    task automatic tick();
        bit q = qreqn, v = req_tvalid, r = tready_raw, l = req_tlast, i = idle, rs = rst_n;
        if (v && tready_f) beats++;
        @(posedge clk);
        cyc++;
        if (!rs) begin
            mf = mdl_reset(); md = mdl_reset();
        end else begin
            mf = step(mf, 1'b1, q, v, r, l, i, cyc);
            md = step(md, 1'b0, q, v, r, l, i, cyc);
        end
        #1;
        cmp_all();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".stall"}, stall_f, 1'b0);     chk({tag, ".prst"}, prst_f, 1'b0);
        chk({tag, ".qacceptn"}, qacceptn_f, 1'b1); chk({tag, ".qdeny"}, qdeny_f, 1'b0);
        chk({tag, ".qactive"}, qactive_f, 1'b0); chk({tag, ".fcnt"}, fcnt_f, 8'd0);
        chk({tag, ".d_qdeny"}, qdeny_d, 1'b0);   chk({tag, ".d_stall"}, stall_d, 1'b0);
    endtask

    initial begin
        int d0;
        int found;
        checks = 0; errors = 0; cyc = 0; beats = 0;
        mf = mdl_reset(); md = mdl_reset();
        rst_n = 1'b1; qreqn = 1'b1; req_tvalid = 1'b0; tready_raw = 1'b1;
        req_tlast = 1'b0; idle = 1'b1;

        // reset
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        cyc = 0;

        // clean entry and exit
        while (cyc < 10) tick();
        qreqn = 1'b0;
        tick();
        tick(); chk("clean.stall_at_12", stall_f, 1'b1);
        tick(); chk("clean.qacceptn_at_13", qacceptn_f, 1'b0);
        while (cyc < 20) tick();
        qreqn = 1'b1;
        tick();
        chk("clean.stall_rel", stall_f, 1'b0);
        chk("clean.qacceptn_rel", qacceptn_f, 1'b1);
        tick();

        // mid-packet request: 4-beat packet, beat 1 accepted before qreqn falls
        beats = 0;
        req_tvalid = 1'b1; tready_raw = 1'b1; req_tlast = 1'b0;
        tick();
        qreqn = 1'b0;
        tick(); chk("midpkt.stall_b2", stall_f, 1'b0); chk("midpkt.ready_b2", tready_f, 1'b1);
        tick(); chk("midpkt.stall_b3", stall_f, 1'b0); chk("midpkt.ready_b3", tready_f, 1'b1);
        req_tlast = 1'b1;
        tick(); chk("midpkt.stall_after_last", stall_f, 1'b1);
        req_tvalid = 1'b0; req_tlast = 1'b0;
        tick();
        chk("midpkt.beats", beats, 4);
        chk("midpkt.qacceptn", qacceptn_f, 1'b0);
        qreqn = 1'b1;
        tick(); tick();

        // slow drain
        idle = 1'b0; qreqn = 1'b0;
        tick(); tick(); chk("slow.stall", stall_f, 1'b1);
        repeat (5) tick();
        idle = 1'b1;
        tick();
        chk("slow.qacceptn", qacceptn_f, 1'b0);
        chk("slow.prst", prst_f, 1'b0);
        chk("slow.fcnt", fcnt_f, 8'd0);
        qreqn = 1'b1;
        tick(); tick();

        // forced flush / deny
        idle = 1'b0; qreqn = 1'b0;
        tick(); tick();
        d0 = cyc;
        while (cyc < d0 + T - 1) tick();
        chk("flush.prst_early", prst_f, 1'b0);
        tick();
        chk("flush.prst_at_16", prst_f, 1'b1);
        chk("deny.qdeny_at_16", qdeny_d, 1'b1);
        chk("deny.stall_at_16", stall_d, 1'b0);
        repeat (3) tick();
        idle = 1'b1;
        tick();
        chk("flush.prst_exit", prst_f, 1'b0);
        chk("flush.qacceptn", qacceptn_f, 1'b0);
        chk("flush.fcnt1", fcnt_f, 8'd1);
        qreqn = 1'b1;
        tick();
        chk("deny.qdeny_rel", qdeny_d, 1'b0);
        chk("flush.qacceptn_rel", qacceptn_f, 1'b1);

        // repeated flushes drive the counter into saturation
        for (int n = 0; n < 299; n++) begin
            qreqn = 1'b0; idle = 1'b0;
            repeat (2 + T + 3) tick();
            idle = 1'b1;
            tick();
            qreqn = 1'b1;
            tick();
        end
        chk("flush.saturated", fcnt_f, 8'd255);
        chk("deny.fcnt_zero", fcnt_d, 8'd0);

        // randomized traffic, idle and Q-channel activity
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) qreqn = ~qreqn;
            if ($urandom_range(9) == 0) idle = ~idle;
            req_tvalid = 1'($urandom_range(1));
            tready_raw = 1'($urandom_range(3) != 0);
            req_tlast  = 1'($urandom_range(2) == 0);
            tick();
        end

        // settle back to RUN with no open packet
        qreqn = 1'b1; idle = 1'b1; req_tvalid = 1'b1; tready_raw = 1'b1; req_tlast = 1'b1;
        repeat (6) tick();
        req_tvalid = 1'b0; req_tlast = 1'b0;
        tick();

        // reset in the middle of a flush
        qreqn = 1'b0; idle = 1'b0;
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            tick();
            if (prst_f === 1'b1) found = 1;
        end
        chk("rstflush.reached_flush", found, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rstflush");
        mf = mdl_reset(); md = mdl_reset();
        tick();
        rst_n = 1'b1;
        qreqn = 1'b1; idle = 1'b1;
        tick();
        qreqn = 1'b0;
        tick(); tick();
        chk("rstflush.stall_again", stall_f, 1'b1);
        tick();
        chk("rstflush.qacceptn_again", qacceptn_f, 1'b0);
        qreqn = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
